// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the scan controller and its host: enable and load controls,
// the BCD payload, and the registered digit-drive and status outputs.
interface seg7_scan_ctrl_if #(
    parameter int unsigned N = 4
);
    logic           enable;
    logic           load;
    logic [4*N-1:0] data;
    logic           lzs_en;
    logic [3:0]     bcd;
    logic [N-1:0]   digit_en;
    logic           pending;
    logic           frame_done;

    modport master (
        output enable, load, data, lzs_en,
        input  bcd, digit_en, pending, frame_done
    );

    modport slave (
        input  enable, load, data, lzs_en,
        output bcd, digit_en, pending, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller. Each digit slot begins with a short
// blanking window and then drives one active-low digit select. A new value is
// held in a shadow register and moved to the displayed register only at the
// end of a frame, so a frame never shows a mix of old and new digits.
module seg7_scan_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned DEAD     = 4
) (
    input  logic            clk,
    input  logic            nreset,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = 4 * N;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    state_t          r_state,        w_state_nxt;
    logic [CW-1:0]   r_cnt,          w_cnt_nxt;
    logic [IW-1:0]   r_idx,          w_idx_nxt;
    logic [DW-1:0]   r_active,       w_active_nxt;
    logic [DW-1:0]   r_shadow,       w_shadow_nxt;
    logic            r_active_lzs,   w_active_lzs_nxt;
    logic            r_shadow_lzs,   w_shadow_lzs_nxt;
    logic            r_pending,      w_pending_nxt;
    logic            r_frame_done,   w_frame_done_nxt;
    logic [N-1:0]    r_digit_en,     w_digit_en_nxt;
    logic [3:0]      r_bcd,          w_bcd_nxt;
    logic            w_wrap;

    // Code for digit k: invalid nibbles and suppressed leading zeros go blank.
    function automatic logic [3:0] digit_code(input logic [DW-1:0] val,
                                              input logic          lzs,
                                              input logic [IW-1:0] k);
        logic       upper_zero;
        logic [3:0] nib;
        digit_code = 4'hF;
        upper_zero = 1'b1;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            nib = val[4*i +: 4];
            if (nib != 4'h0) upper_zero = 1'b0;
            if (IW'(i) == k) begin
                if (nib > 4'd9)                          digit_code = 4'hF;
                else if (lzs && (i != 0) && upper_zero)  digit_code = 4'hF;
                else                                     digit_code = nib;
            end
        end
    endfunction

    // State, counters, value registers and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_active     <= '1;
            r_shadow     <= '1;
            r_active_lzs <= 1'b0;
            r_shadow_lzs <= 1'b0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_digit_en   <= '1;
            r_bcd        <= 4'hF;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_active     <= w_active_nxt;
            r_shadow     <= w_shadow_nxt;
            r_active_lzs <= w_active_lzs_nxt;
            r_shadow_lzs <= w_shadow_lzs_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_digit_en   <= w_digit_en_nxt;
            r_bcd        <= w_bcd_nxt;
        end
    end

    // Next-state, slot sequencing, shadow/active transfer and output values.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_idx_nxt        = r_idx;
        w_wrap           = 1'b0;
        w_active_nxt     = r_active;
        w_shadow_nxt     = r_shadow;
        w_active_lzs_nxt = r_active_lzs;
        w_shadow_lzs_nxt = r_shadow_lzs;
        w_pending_nxt    = r_pending;
        w_frame_done_nxt = 1'b0;
        w_digit_en_nxt   = '1;
        w_bcd_nxt        = 4'hF;

        case (r_state)
            ST_OFF: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (bus.enable) w_state_nxt = ST_DEAD;
            end
            ST_DEAD: begin
                if (!bus.enable) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CW'(DEAD - 1)) w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (!bus.enable) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_cnt == CW'(PRESCALE - 1)) begin
                    w_state_nxt = ST_DEAD;
                    w_cnt_nxt   = '0;
                    if (r_idx == IW'(N - 1)) begin
                        w_idx_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        // A load always lands in the shadow; a load on the wrap edge bypasses it.
        if (bus.load) begin
            w_shadow_nxt     = bus.data;
            w_shadow_lzs_nxt = bus.lzs_en;
        end
        if (w_wrap) begin
            if (bus.load) begin
                w_active_nxt     = bus.data;
                w_active_lzs_nxt = bus.lzs_en;
            end else if (r_pending) begin
                w_active_nxt     = r_shadow;
                w_active_lzs_nxt = r_shadow_lzs;
            end
            w_pending_nxt = 1'b0;
        end else if (bus.load) begin
            w_pending_nxt = 1'b1;
        end
        w_frame_done_nxt = w_wrap;

        if (w_state_nxt == ST_ON) w_digit_en_nxt = ~(N'(1) << w_idx_nxt);
        if (w_state_nxt != ST_OFF)
            w_bcd_nxt = digit_code(w_active_nxt, w_active_lzs_nxt, w_idx_nxt);
    end

    assign bus.bcd        = r_bcd;
    assign bus.digit_en   = r_digit_en;
    assign bus.pending    = r_pending;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (N=4, PRESCALE=8, DEAD=2). The reference model
// tracks elapsed cycles since scanning started and derives slot, blanking
// window and frame boundaries from that count with plain arithmetic.
module tb_seg7_scan_ctrl;
    localparam int N     = 4;
    localparam int P     = 8;
    localparam int D     = 2;
    localparam int FRAME = N * P;

    logic clk    = 1'b0;
    logic nreset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    seg7_scan_ctrl_if #(.N(N)) bus();

    seg7_scan_ctrl #(.N(N), .PRESCALE(P), .DEAD(D)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [9:0] dut_out;
    assign dut_out = {bus.digit_en, bus.bcd, bus.pending, bus.frame_done};

    localparam logic [9:0] RESET_OUT = {4'hF, 4'hF, 1'b0, 1'b0};

    // Reference model state.
    bit          m_run;
    int          m_t;
    logic [15:0] m_act, m_sh;
    logic        m_act_lz, m_sh_lz, m_pend, m_fd;

    task automatic model_reset();
        m_run = 0; m_t = 0;
        m_act = 16'hFFFF; m_sh = 16'hFFFF;
        m_act_lz = 1'b0; m_sh_lz = 1'b0; m_pend = 1'b0; m_fd = 1'b0;
    endtask

    function automatic logic [3:0] ref_code(input logic [15:0] v, input logic lz, input int k);
        int msd;
        logic [15:0] s;
        logic [3:0] nib;
        msd = 0;
        for (int i = 0; i < N; i++) begin
            s = v >> (4 * i);
            if (s[3:0] != 4'h0) msd = i;
        end
        s = v >> (4 * k);
        nib = s[3:0];
        if (nib > 4'd9) return 4'hF;
        if (lz && k > msd) return 4'hF;
        return nib;
    endfunction

    function automatic logic [9:0] exp_out();
        logic [3:0] de, b;
        int slot, w;
        if (!m_run) return {4'hF, 4'hF, m_pend, m_fd};
        slot = (m_t / P) % N;
        w    = m_t % P;
        de   = (w < D) ? 4'hF : ~(4'b0001 << slot);
        b    = ref_code(m_act, m_act_lz, slot);
        return {de, b, m_pend, m_fd};
    endfunction

    // Drive one cycle of inputs, advance the model over the edge, land on negedge.
    task automatic step(input logic en, input logic ld, input logic [15:0] dat, input logic lz);
        bit wrap;
        bus.enable = en; bus.load = ld; bus.data = dat; bus.lzs_en = lz;
        @(posedge clk);
        if (!nreset) begin
            model_reset();
        end else begin
            wrap = 0;
            if (!en) m_run = 0;
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else begin m_t++; wrap = (m_t % FRAME == 0); end
            if (ld) begin m_sh = dat; m_sh_lz = lz; end
            if (wrap) begin
                if (ld) begin m_act = dat; m_act_lz = lz; end
                else if (m_pend) begin m_act = m_sh; m_act_lz = m_sh_lz; end
                m_pend = 1'b0;
            end else if (ld) begin
                m_pend = 1'b1;
            end
            m_fd = wrap;
        end
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (dut_out !== RESET_OUT) begin
            failures++; $display("FAIL reset_async got=%h exp=%h", dut_out, RESET_OUT);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16'h1234, 1'b0);
            checks++;
            if (dut_out !== RESET_OUT) begin
                failures++; $display("FAIL reset_hold got=%h exp=%h", dut_out, RESET_OUT);
            end
        end
        nreset = 1'b1;
    endtask

    task automatic test_basic();
        int on4, blank;
        on4 = 0; blank = 0;
        step(1'b1, 1'b1, 16'h1234, 1'b0);
        checks++;
        if (dut_out !== exp_out()) begin
            failures++; $display("FAIL basic_first got=%h exp=%h", dut_out, exp_out());
        end
        for (int i = 1; i < 3 * FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL basic t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
            if (i >= FRAME) begin
                if (bus.digit_en == 4'b1110 && bus.bcd == 4'h4) on4++;
                if (bus.digit_en == 4'b1111) blank++;
            end
        end
        checks++;
        if (on4 != 12 || blank != 16) begin
            failures++; $display("FAIL basic_slot_times on4=%0d blank=%0d exp 12 16", on4, blank);
        end
    endtask

    task automatic test_lzs();
        int nf, nz;
        step(1'b1, 1'b1, 16'h0042, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL lzs42 t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
        end
        nf = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            if (bus.digit_en != 4'hF && bus.bcd == 4'hF) nf++;
        end
        checks++;
        if (nf != 12) begin
            failures++; $display("FAIL lzs42_blank got=%0d exp=12", nf);
        end
        step(1'b1, 1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL lzs0 t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
        end
        nf = 0; nz = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            if (bus.digit_en != 4'hF && bus.bcd == 4'hF) nf++;
            if (bus.digit_en == 4'b1110 && bus.bcd == 4'h0) nz++;
        end
        checks++;
        if (nf != 18 || nz != 6) begin
            failures++; $display("FAIL lzs0_digits blank=%0d zero=%0d exp 18 6", nf, nz);
        end
    endtask

    task automatic test_double_load();
        int n, fd, ones;
        n = 0;
        while (!(m_run && m_t % FRAME == 9) && n < 100) begin
            step(1'b1, 1'b0, 16'h0, 1'b0); n++;
        end
        checks++;
        if (n >= 100) begin failures++; $display("FAIL dbl_align timeout"); end
        step(1'b1, 1'b1, 16'h1111, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h2222, 1'b0);
        checks++;
        if (bus.pending !== 1'b1) begin
            failures++; $display("FAIL dbl_pending got=%b exp=1", bus.pending);
        end
        fd = 0; ones = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL dbl t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
            if (bus.frame_done) fd++;
            if (bus.digit_en != 4'hF && bus.bcd == 4'h1) ones++;
        end
        checks++;
        if (fd != 2 || ones != 0) begin
            failures++; $display("FAIL dbl_frames fd=%0d ones=%0d exp 2 0", fd, ones);
        end
    endtask

    task automatic test_wrap_load();
        int n, c8;
        n = 0;
        while (!(m_run && m_t % FRAME == FRAME - 1) && n < 100) begin
            step(1'b1, 1'b0, 16'h0, 1'b0); n++;
        end
        checks++;
        if (n >= 100) begin failures++; $display("FAIL wrap_align timeout"); end
        step(1'b1, 1'b1, 16'h5678, 1'b0);
        checks++;
        if (bus.pending !== 1'b0 || bus.frame_done !== 1'b1) begin
            failures++; $display("FAIL wrap_edge pending=%b fd=%b exp 0 1", bus.pending, bus.frame_done);
        end
        c8 = 0;
        for (int i = 0; i < FRAME - 1; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL wrap t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
            if (bus.digit_en == 4'b1110 && bus.bcd == 4'h8) c8++;
        end
        checks++;
        if (c8 != 6) begin failures++; $display("FAIL wrap_next_frame got=%0d exp=6", c8); end
    endtask

    task automatic test_enable_drop();
        int n;
        n = 0;
        while (!(m_run && (m_t / P) % N == 2 && m_t % P == 4) && n < 100) begin
            step(1'b1, 1'b0, 16'h0, 1'b0); n++;
        end
        checks++;
        if (n >= 100) begin failures++; $display("FAIL drop_align timeout"); end
        checks++;
        if (bus.digit_en !== 4'b1011) begin
            failures++; $display("FAIL drop_pre got=%b exp=1011", bus.digit_en);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== {4'hF, 4'hF, 2'b00}) begin
                failures++; $display("FAIL drop_off got=%h exp=%h", dut_out, {4'hF, 4'hF, 2'b00});
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL drop_re t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
        end
        checks++;
        if (bus.digit_en !== 4'b1110) begin
            failures++; $display("FAIL drop_restart got=%b exp=1110", bus.digit_en);
        end
    endtask

    task automatic test_load_off();
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h9876, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if (dut_out !== {4'hF, 4'hF, 1'b1, 1'b0}) begin
            failures++; $display("FAIL off_pending got=%h exp=%h", dut_out, {4'hF, 4'hF, 1'b1, 1'b0});
        end
        for (int i = 0; i < FRAME + 8; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL off_apply t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
        end
        checks++;
        if (bus.pending !== 1'b0) begin failures++; $display("FAIL off_cleared got=%b exp=0", bus.pending); end
    endtask

    task automatic test_async_reset();
        int nf;
        step(1'b1, 1'b1, 16'h12A4, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        nf = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL rst_hexa t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
            if (bus.digit_en == 4'b1101 && bus.bcd == 4'hF) nf++;
        end
        checks++;
        if (nf != 6) begin failures++; $display("FAIL rst_hexa_blank got=%0d exp=6", nf); end
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (dut_out !== RESET_OUT) begin
            failures++; $display("FAIL rst_mid got=%h exp=%h", dut_out, RESET_OUT);
        end
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL rst_after t=%0d got=%h exp=%h", m_t, dut_out, exp_out());
            end
        end
    endtask

    task automatic test_random();
        logic en, ld, lz;
        logic [15:0] d;
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 29) != 0);
            ld = ($urandom_range(0, 11) == 0);
            lz = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++)
                d[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step(en, ld, d, lz);
            checks++;
            if (dut_out !== exp_out()) begin
                failures++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_out, exp_out());
            end
        end
    endtask

    initial begin
        bus.enable = 1'b0; bus.load = 1'b0; bus.data = '0; bus.lzs_en = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_lzs();
        test_double_load();
        test_wrap_load();
        test_enable_drop();
        test_load_off();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
